// File: rtl/regfile_sb_if.sv
// Bus bundle for the register file: two read ports, one write port and the
// scoreboard alloc/count signals.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Read_reg1;
    logic [ADDR_W-1:0] Read_reg2;
    logic [DATA_W-1:0] Read_data1;
    logic [DATA_W-1:0] Read_data2;
    logic              Read_busy1;
    logic              Read_busy2;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_reg;
    logic [DATA_W-1:0] Data;
    logic              Alloc;
    logic [ADDR_W-1:0] Alloc_reg;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output Read_reg1, Read_reg2, RegWrite, Write_reg, Data, Alloc, Alloc_reg,
        input  Read_data1, Read_data2, Read_busy1, Read_busy2, busy_cnt
    );

    modport slave (
        input  Read_reg1, Read_reg2, RegWrite, Write_reg, Data, Alloc, Alloc_reg,
        output Read_data1, Read_data2, Read_busy1, Read_busy2, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// General-purpose register array with zero register, optional write bypass
// and a per-register busy scoreboard with a registered busy count.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [ADDR_W:0]   busy_cnt_r;

    logic              wr_en_s;
    logic              alloc_en_s;
    logic [DEPTH-1:0]  wr_mask_s;
    logic [DEPTH-1:0]  alloc_mask_s;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic              cnt_inc_s;
    logic              cnt_dec_s;
    logic [ADDR_W:0]   busy_cnt_nxt_s;
    logic [DATA_W-1:0] rd_data1_s;
    logic [DATA_W-1:0] rd_data2_s;
    logic              rd_busy1_s;
    logic              rd_busy2_s;

    assign wr_en_s    = rf.RegWrite && (rf.Write_reg != {ADDR_W{1'b0}});
    assign alloc_en_s = rf.Alloc    && (rf.Alloc_reg != {ADDR_W{1'b0}});

    // Busy vector next state; alloc is ORed in last so it wins over a same-address clear.
    always_comb begin
        wr_mask_s    = {DEPTH{1'b0}};
        alloc_mask_s = {DEPTH{1'b0}};
        if (wr_en_s) begin
            wr_mask_s = {{(DEPTH-1){1'b0}}, 1'b1} << rf.Write_reg;
        end else begin
            wr_mask_s = {DEPTH{1'b0}};
        end
        if (alloc_en_s) begin
            alloc_mask_s = {{(DEPTH-1){1'b0}}, 1'b1} << rf.Alloc_reg;
        end else begin
            alloc_mask_s = {DEPTH{1'b0}};
        end
        busy_nxt_s = (busy_r & ~wr_mask_s) | alloc_mask_s;
    end

    // Incremental count update: only real 0->1 and 1->0 transitions move it.
    always_comb begin
        cnt_inc_s      = alloc_en_s && !busy_r[rf.Alloc_reg];
        cnt_dec_s      = wr_en_s && busy_r[rf.Write_reg] &&
                         !(alloc_en_s && (rf.Alloc_reg == rf.Write_reg));
        busy_cnt_nxt_s = busy_cnt_r;
        case ({cnt_inc_s, cnt_dec_s})
            2'b10:   busy_cnt_nxt_s = busy_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   busy_cnt_nxt_s = busy_cnt_r - {{ADDR_W{1'b0}}, 1'b1};
            default: busy_cnt_nxt_s = busy_cnt_r;
        endcase
    end

    // Register storage; address 0 is never written so it stays at reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[rf.Write_reg] <= rf.Data;
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
        end
    end

    // Read port 1: zero register, then bypass, then stored state.
    always_comb begin
        rd_data1_s = {DATA_W{1'b0}};
        rd_busy1_s = 1'b0;
        if (rf.Read_reg1 == {ADDR_W{1'b0}}) begin
            rd_data1_s = {DATA_W{1'b0}};
            rd_busy1_s = 1'b0;
        end else if ((BYPASS != 0) && wr_en_s && (rf.Write_reg == rf.Read_reg1)) begin
            rd_data1_s = rf.Data;
            rd_busy1_s = 1'b0;
        end else begin
            rd_data1_s = mem_r[rf.Read_reg1];
            rd_busy1_s = busy_r[rf.Read_reg1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2_s = {DATA_W{1'b0}};
        rd_busy2_s = 1'b0;
        if (rf.Read_reg2 == {ADDR_W{1'b0}}) begin
            rd_data2_s = {DATA_W{1'b0}};
            rd_busy2_s = 1'b0;
        end else if ((BYPASS != 0) && wr_en_s && (rf.Write_reg == rf.Read_reg2)) begin
            rd_data2_s = rf.Data;
            rd_busy2_s = 1'b0;
        end else begin
            rd_data2_s = mem_r[rf.Read_reg2];
            rd_busy2_s = busy_r[rf.Read_reg2];
        end
    end

    assign rf.Read_data1 = rd_data1_s;
    assign rf.Read_data2 = rd_data2_s;
    assign rf.Read_busy1 = rd_busy1_s;
    assign rf.Read_busy2 = rd_busy2_s;
    assign rf.busy_cnt   = busy_cnt_r;
endmodule
